// File: rtl/systolic_drain_pkg.sv
// systolic_drain_pkg
// Shared definitions for the systolic result-drain stage: default geometry,
// derived widths and the drain FSM state encoding.
// No ports (package).
package systolic_drain_pkg;

  // Default geometry of the upstream array.
  localparam int W_DEF   = 32;
  localparam int N_DEF   = 3;
  localparam int LAT_DEF = 8;

  // Widths derived from the default geometry.
  localparam int ELEMS = N_DEF * N_DEF;
  localparam int IDXW  = $clog2(ELEMS);
  localparam int CNTW  = $clog2(LAT_DEF + 1);

  // Drain FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_drain_ctr.sv
// drain_ctr
// Loadable down-counter with a zero flag. It times the compute latency
// between an accepted start and the snapshot of the array results.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset (count returns to 0)
//   i_load     load i_load_val this cycle (wins over i_dec)
//   i_load_val value to load
//   i_dec      decrement by one; saturates at zero
//   o_zero     count is zero
module drain_ctr #(
  parameter int CNTW = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [CNTW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [CNTW-1:0] cnt_r;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= {CNTW{1'b0}};
    end else if (i_load) begin
      cnt_r <= i_load_val;
    end else if (i_dec && (cnt_r != {CNTW{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_zero = (cnt_r == {CNTW{1'b0}});

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain
// Result-drain stage behind the systolic array controller. After an
// accepted start it waits LAT cycles, snapshots the flat accumulator bus,
// pulses an accumulator clear, and streams the N*N results in row-major
// order over a valid/ready interface.
// Ports:
//   i_clk, i_rst  clock (rising) / asynchronous active-high reset
//   i_start       one-cycle job start pulse
//   i_C           flat array result bus, element k at [2W*(k+1)-1 : 2W*k]
//   i_ready       downstream accepts o_data this cycle
//   o_valid       o_data/o_row/o_col/o_last are valid
//   o_data        current result element (2W bits)
//   o_row, o_col  indices of the current element
//   o_last        current element is the final one of the job
//   o_busy        block is waiting or streaming
//   o_clr         one-cycle accumulator clear request
//   o_drop        one-cycle pulse: a start was ignored
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int N   = N_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [2*W*N*N-1:0]     i_C,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [2*W-1:0]         o_data,
  output logic [$clog2(N)-1:0]   o_row,
  output logic [$clog2(N)-1:0]   o_col,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_clr,
  output logic                   o_drop
);

  localparam int DW = 2 * W;
  localparam int NE = N * N;
  localparam int KW = $clog2(NE);
  localparam int CW = $clog2(LAT + 1);
  localparam int RW = $clog2(N);

  localparam logic [KW-1:0] K_LAST   = KW'(NE - 1);
  localparam logic [RW-1:0] RC_LAST  = RW'(N - 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(LAT - 1);

  state_e             state_r;
  logic [KW-1:0]      k_r;
  logic [RW-1:0]      row_r;
  logic [RW-1:0]      col_r;
  logic [DW*NE-1:0]   snap_r;
  logic               clr_r;
  logic               drop_r;

  logic               valid_s;
  logic               hs_s;
  logic               last_s;
  logic               ctr_load_s;
  logic               ctr_dec_s;
  logic               cnt_zero_s;

  // Latency counter for the WAIT phase.
  drain_ctr #(
    .CNTW (CW)
  ) u_ctr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ctr_load_s),
    .i_load_val (LAT_LOAD),
    .i_dec      (ctr_dec_s),
    .o_zero     (cnt_zero_s)
  );

  // Handshake decode and counter control, all derived from registered state.
  always_comb begin
    valid_s    = (state_r == STREAM);
    hs_s       = valid_s && i_ready;
    last_s     = (k_r == K_LAST);
    ctr_load_s = 1'b0;
    ctr_dec_s  = 1'b0;
    case (state_r)
      IDLE:    ctr_load_s = i_start;
      WAIT:    ctr_dec_s  = !cnt_zero_s;
      // A start coinciding with the final handshake chains the next job.
      STREAM:  ctr_load_s = hs_s && last_s && i_start;
      default: ctr_load_s = 1'b0;
    endcase
  end

  // Drain FSM: state, element index, row/col tracking, snapshot and pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      k_r     <= {KW{1'b0}};
      row_r   <= {RW{1'b0}};
      col_r   <= {RW{1'b0}};
      snap_r  <= {(DW*NE){1'b0}};
      clr_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      clr_r  <= 1'b0;
      drop_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          drop_r <= i_start;
          if (cnt_zero_s) begin
            // Snapshot decouples the stream from further array activity.
            snap_r  <= i_C;
            k_r     <= {KW{1'b0}};
            row_r   <= {RW{1'b0}};
            col_r   <= {RW{1'b0}};
            clr_r   <= 1'b1;
            state_r <= STREAM;
          end else begin
            state_r <= WAIT;
          end
        end
        STREAM: begin
          if (hs_s && last_s) begin
            state_r <= i_start ? WAIT : IDLE;
          end else begin
            drop_r <= i_start;
            if (hs_s) begin
              k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
              // Row/col wrap counters avoid dividing k by N.
              if (col_r == RC_LAST) begin
                col_r <= {RW{1'b0}};
                row_r <= row_r + {{(RW-1){1'b0}}, 1'b1};
              end else begin
                col_r <= col_r + {{(RW-1){1'b0}}, 1'b1};
              end
            end else begin
              k_r <= k_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_valid = valid_s;
  assign o_data  = snap_r[k_r*DW +: DW];
  assign o_row   = row_r;
  assign o_col   = col_r;
  assign o_last  = valid_s && last_s;
  assign o_busy  = (state_r != IDLE);
  assign o_clr   = clr_r;
  assign o_drop  = drop_r;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain
// Scoreboard bench for systolic_drain with W=8, N=3, LAT=8 and an array
// bus whose element k holds 16'h0100+k.
module tb_systolic_drain;

  logic         clk;
  logic         rst;
  logic         start;
  logic [143:0] c_bus;
  logic         ready;
  logic         valid;
  logic [15:0]  data;
  logic [1:0]   row;
  logic [1:0]   col;
  logic         last;
  logic         busy;
  logic         clr;
  logic         drop;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  logic [31:0] sb[$];

  systolic_drain #(
    .W   (8),
    .N   (3),
    .LAT (8)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_C     (c_bus),
    .i_ready (ready),
    .o_valid (valid),
    .o_data  (data),
    .o_row   (row),
    .o_col   (col),
    .o_last  (last),
    .o_busy  (busy),
    .o_clr   (clr),
    .o_drop  (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] item(input int k);
    return {11'd0, 1'(k == 8), 2'(k / 3), 2'(k % 3), 16'h0100 + 16'(k)};
  endfunction

  function automatic logic [31:0] obs();
    return {11'd0, last, row, col, data};
  endfunction

  task automatic push_job();
    for (int k = 0; k < 9; k++) sb.push_back(item(k));
  endtask

  task automatic set_pattern();
    for (int k = 0; k < 9; k++) c_bus[16*k +: 16] = 16'h0100 + 16'(k);
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Job starting now; extra starts sampled at edges s1/s2 relative to E0.
  task automatic run_timed(input int s1, input int s2);
    @(posedge clk); #1;
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e <= 18; e++) begin
      check("valid_t", valid, 32'((e >= 8) && (e <= 16)));
      check("clr_t",   clr,   32'(e == 8));
      check("drop_t",  drop,  32'((e == s1) || (e == s2)));
      check("busy_t",  busy,  32'(e <= 16));
      start = (e == s1 - 1) || (e == s2 - 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("timed_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int c;
    int hs0;
    logic        prev_stall;
    logic [31:0] prev_obs;

    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    c_bus = 144'd0;
    set_pattern();
    prev_stall = 1'b0;
    prev_obs   = 32'd0;

    // Output monitor: scoreboard pops on handshakes, hold checks on stalls.
    fork
      forever begin
        @(negedge clk);
        if (prev_stall) begin
          check("stall_valid", valid, 32'd1);
          check("stall_hold", obs(), prev_obs);
        end
        if (valid && ready) begin
          if (sb.size() == 0) check("sb_underflow", sb.size(), 32'd1);
          else check("elem", obs(), sb.pop_front());
          hs_cnt++;
        end
        prev_stall = valid && !ready;
        prev_obs   = obs();
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 32'd0);
    check("rst_data",  data,  32'd0);
    check("rst_rowcol", {row, col}, 32'd0);
    check("rst_flags", {last, busy, clr, drop}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single job, ready held high
    hs0 = hs_cnt;
    run_timed(-1, -1);
    check("single_count", hs_cnt - hs0, 32'd9);

    // Backpressure with ready pattern 1,0,0,...
    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_cnt;
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (sb.size() != 0 && c < 200) begin
      ready = (c % 3 == 0);
      @(posedge clk); #1;
      c++;
    end
    ready = 1'b1;
    check("bp_drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_count", hs_cnt - hs0, 32'd9);
    check("bp_idle", valid, 32'd0);

    // Snapshot isolation
    @(posedge clk); #1;
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("iso_valid_seen", valid, 32'd1);
    c_bus = {144{1'b1}};
    drain("iso_drain");
    set_pattern();
    repeat (3) @(posedge clk);

    // Ignored starts in WAIT and STREAM
    hs0 = hs_cnt;
    run_timed(3, 10);
    repeat (10) @(posedge clk);
    #1;
    check("drop_count", hs_cnt - hs0, 32'd9);
    check("drop_idle", busy, 32'd0);

    // Chained start on the final handshake
    @(posedge clk); #1;
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("chain_pre_last", last, 32'd1);
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
    check("chain_drop", drop, 32'd0);
    check("chain_busy", busy, 32'd1);
    check("chain_valid", valid, 32'd0);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      check("chain_valid_j", valid, 32'(j == 8));
      check("chain_busy_j", busy, 32'd1);
      check("chain_drop_j", drop, 32'd0);
    end
    drain("chain_drain");
    repeat (3) @(posedge clk);

    // Reset mid-stream at the 4th element
    @(posedge clk); #1;
    start = 1'b1;
    push_job();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("mid_pre_data", data, 32'h0103);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_valid", valid, 32'd0);
    check("mid_rst_data", data, 32'd0);
    check("mid_rst_rowcol", {row, col}, 32'd0);
    check("mid_rst_flags", {last, busy, clr, drop}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      check("post_rst_valid", valid, 32'd0);
      check("post_rst_busy", busy, 32'd0);
    end

    // Recovery job after reset
    hs0 = hs_cnt;
    run_timed(-1, -1);
    check("recover_count", hs_cnt - hs0, 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result-drain stage directly downstream of the 3x3 systolic array controller. Watches a job-start pulse and waits a fixed compute latency. Snapshots the array's flat accumulator bus, then streams the N*N results out one element per handshake, in row-major order, over a valid/ready interface. It also pulses an accumulator-clear so the array is free for the next job while the snapshot drains.

## Interface
- W, 32, operand width; each result element is 2*W bits
- N, 3, array dimension; N*N elements per job
- LAT, 8, cycles from sampled i_start to a stable array result; legal range LAT >= 1
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse: first skewed operands entered the array this cycle
- i_C  in  2*W*N*N  array results; element k = r*N+c occupies bits [2W*(k+1)-1 : 2W*k]
- i_ready  in  1  downstream can accept o_data this cycle
- o_valid  out  1  o_data/o_row/o_col/o_last are valid
- o_data  out  2*W  current result element
- o_row, o_col  out  $clog2(N) each  indices of current element
- o_last  out  1  current element is k = N*N-1
- o_busy  out  1  block is in WAIT or STREAM
- o_clr  out  1  one-cycle pulse requesting array accumulator clear
- o_drop  out  1  one-cycle pulse: i_start was ignored

## Operation
- States: IDLE, WAIT, STREAM.
- IDLE with i_start=1: go to WAIT and load cnt = LAT-1.
- WAIT, cnt != 0: decrement cnt.
- WAIT, cnt == 0: capture i_C into the snapshot register, set k=0, go to STREAM, and pulse o_clr for one cycle.
- STREAM: o_valid=1 and o_data = snapshot element k; o_row = k / N, o_col = k % N.
- A handshake occurs when o_valid && i_ready.
  - On a handshake with k < N*N-1: k increments.
  - On a handshake with k = N*N-1: go to IDLE.
- o_valid never drops without a handshake. While o_valid && !i_ready, all output fields hold stable.
- i_start is ignored while in WAIT or STREAM, except in the cycle of the final handshake. An ignored i_start raises o_drop for one cycle. In the final-handshake cycle, i_start is accepted and the next state is WAIT (not IDLE), with no drop.
- The snapshot is isolated from i_C after capture. Array activity during STREAM does not affect streamed data.
- o_busy = (state != IDLE).

## Timing
- Reset, asynchronous: state=IDLE, cnt=0, k=0, snapshot=0. o_valid, o_last, o_busy, o_clr and o_drop are 0. o_data, o_row and o_col are 0.
- Reset asserted mid-job aborts the job; no partial stream resumes after release.
- Let E0 be the edge that samples i_start=1. Capture occurs at edge E0+LAT, and o_valid is high from that edge onward.
- o_clr is high for exactly the cycle following edge E0+LAT.
- With i_ready held at 1: one element per cycle, N*N cycles, then o_valid falls.
- With back-to-back accepted jobs, the minimum start-to-start spacing is LAT+N*N cycles.
- All outputs are driven from registers or from the state/k/snapshot registers. Nothing combinational passes from i_ready to o_valid.

## Structure
- Shared package (or include): state encodings IDLE/WAIT/STREAM, and localparams ELEMS = N*N, IDXW = $clog2(ELEMS), CNTW = $clog2(LAT+1).
- One natural sub-module: drain_ctr, a loadable down-counter with a zero flag, used for the WAIT latency.
- Element select is a plain indexed part-select of the snapshot by k.
- Index split into row/col uses a small row/col counter pair rather than a divider.

## Test plan
All tests use W=8, N=3, LAT=8, and i_C with element k = 16'h0100+k.
- Single job, i_ready=1: pulse i_start at edge 0.
  - Required: o_valid rises at edge 8; o_clr is high in cycle 8 only.
  - Data 0100..0108 appears on consecutive cycles, with (row,col) = (0,0)..(2,2).
  - o_last is high only with 0108; o_valid is low from edge 17.
- Backpressure: same job, i_ready toggling 1,0,0,1,...
  - Required: every element appears exactly once, in order.
  - o_data holds stable throughout each stall.
- Snapshot isolation: change i_C to all 16'hFFFF one cycle after capture.
  - Required: the stream still yields 0100..0108.
- Ignored start: pulse i_start at edge 3 (WAIT) and at edge 10 (STREAM).
  - Required: o_drop pulses in both cycles; only one stream of 9 is produced.
- Chained start: assert i_start in the cycle of the 0108 handshake.
  - Required: no o_drop, and o_busy stays 1.
  - A new o_valid arrives 8 edges after that handshake.
- Reset mid-stream: assert i_rst asynchronously at the 4th element.
  - Required: all outputs go to 0 immediately.
  - After release, the block stays in IDLE and o_valid stays 0 until a new i_start.
